// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package hazard_pkg;

  // Register index width shared by the hazard and forwarding logic.
  localparam int RWIDTH = 5;

  // Architectural zero register; writes to it never create a dependency.
  localparam logic [RWIDTH-1:0] ZERO_REG = '0;

  // Width of the mult/div countdown (covers latencies up to 65535).
  localparam int MD_CNT_W = 16;

  // Sequencer states: normal flow, or waiting on a multi-cycle mult/div.
  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  // Per-stage enable/flush bundle driven to the pipeline registers.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
  } ctrl_t;

  // All enables set, no flushes: the pipe advances normally.
  localparam ctrl_t CTRL_ADVANCE = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
    idex_flush: 1'b0, exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1
  };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the EX instruction is a load whose destination
// is read by the instruction currently in ID. Purely combinational.
module load_use_detect #(
  parameter int RWIDTH = hazard_pkg::RWIDTH
) (
  input  logic [RWIDTH-1:0] id_rs,
  input  logic [RWIDTH-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [RWIDTH-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  output logic              luse
);
  import hazard_pkg::*;

  logic rd_live;
  logic rs_hit;
  logic rt_hit;

  // A load to the zero register produces no usable value, so it never stalls.
  always_comb begin
    rd_live = ex_mem_read & ex_reg_write & (ex_rd != RWIDTH'(ZERO_REG));
    rs_hit  = id_uses_rs & (id_rs == ex_rd);
    rt_hit  = id_uses_rt & (id_rt == ex_rd);
    luse    = rd_live & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: per-stage enable/flush strobes for load-use
// stalls, mult/div front-end bubbling, data-memory freeze and branch squash,
// plus a saturating count of cycles in which the PC did not advance.
module pipe_hazard_ctrl #(
  parameter int RWIDTH    = hazard_pkg::RWIDTH,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RWIDTH-1:0] id_rs,
  input  logic [RWIDTH-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [RWIDTH-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic              md_start,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              exmem_flush,
  output logic              memwb_en,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt
);
  import hazard_pkg::*;

  // Countdown preload: the issue cycle is spent in RUN, the rest in MD_WAIT.
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES - 2);

  state_e              state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                luse;
  logic                memstall;
  ctrl_t               ctrl;

  load_use_detect #(.RWIDTH(RWIDTH)) u_luse (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .luse         (luse)
  );

  assign memstall = mem_req & ~dmem_ready;

  // Strobe decode and next-state: memstall > MD_WAIT > luse > branch > normal.
  always_comb begin
    ctrl     = '0;
    state_d  = state_q;
    // The divider runs on its own, so the countdown continues even when frozen.
    md_cnt_d = (md_cnt_q != '0) ? md_cnt_q - 1'b1 : md_cnt_q;

    if (reset) begin
      ctrl = '0;
    end else if (memstall) begin
      ctrl = '0;
    end else if (state_q == MD_WAIT) begin
      ctrl.exmem_en    = 1'b1;
      ctrl.exmem_flush = 1'b1;
      ctrl.memwb_en    = 1'b1;
      if (md_cnt_q == '0) begin
        state_d = RUN;
      end
    end else if (luse) begin
      // Hold PC and IF/ID; ID/EX captures one bubble while the load moves on.
      ctrl.idex_en    = 1'b1;
      ctrl.idex_flush = 1'b1;
      ctrl.exmem_en   = 1'b1;
      ctrl.memwb_en   = 1'b1;
    end else if (md_start) begin
      ctrl     = CTRL_ADVANCE;
      state_d  = MD_WAIT;
      md_cnt_d = MD_LOAD;
    end else if (branch_taken) begin
      ctrl            = CTRL_ADVANCE;
      ctrl.ifid_flush = 1'b1;
    end else begin
      ctrl = CTRL_ADVANCE;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctrl.pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State, mult/div countdown and performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_en     = ctrl.idex_en;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_en    = ctrl.exmem_en;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_en    = ctrl.memwb_en;
  assign md_busy     = (state_q == MD_WAIT);
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MD_CYCLES=4 and a 16-bit counter.
// Strobe vector order: {pc, ifid, ifid_flush, idex, idex_flush, exmem, exmem_flush, memwb}.
module tb_pipe_hazard_ctrl;

  localparam int RW = 5;

  // Expected strobe patterns.
  localparam logic [7:0] V_NORM   = 8'hD5;
  localparam logic [7:0] V_BRANCH = 8'hF5;
  localparam logic [7:0] V_LUSE   = 8'h0D;  // compared with idex_en masked off
  localparam logic [7:0] M_LUSE   = 8'hEF;
  localparam logic [7:0] V_MDWAIT = 8'h07;
  localparam logic [7:0] V_FROZEN = 8'h00;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] id_rs, id_rt, ex_rd;
  logic          id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write;
  logic          md_start, branch_taken, mem_req, dmem_ready;
  logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic          exmem_en, exmem_flush, memwb_en, md_busy;
  logic [15:0]   stall_cnt;
  logic [7:0]    vec;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign vec = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en};

  pipe_hazard_ctrl #(.RWIDTH(RW), .MD_CYCLES(4), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .md_start     (md_start),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_flush   (idex_flush),
    .exmem_en     (exmem_en),
    .exmem_flush  (exmem_flush),
    .memwb_en     (memwb_en),
    .md_busy      (md_busy),
    .stall_cnt    (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic clr();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    md_start = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // Commit the current inputs on the next rising edge, then settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_r8();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    @(negedge clk);
    chk("rst_vec", 32'(vec), 32'(V_FROZEN));
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("idle_vec", 32'(vec), 32'(V_NORM));

    // Load-use on rs with a simultaneous taken branch: stall only.
    load_r8(); id_rs = 5'd8; id_uses_rs = 1'b1; branch_taken = 1'b1;
    #1;
    chk("luse_rs_vec", 32'(vec & M_LUSE), 32'(V_LUSE));
    step();
    chk("luse_cnt", 32'(stall_cnt), 32'd1);

    // Load has moved on; branch re-presented alone.
    clr(); branch_taken = 1'b1;
    #1;
    chk("branch_vec", 32'(vec), 32'(V_BRANCH));
    step();

    // Load to r0 never stalls.
    clr(); ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0; id_uses_rs = 1'b1;
    #1;
    chk("r0_vec", 32'(vec), 32'(V_NORM));
    step();

    // Matching registers that are not actually read.
    clr(); load_r8(); id_rs = 5'd8; id_rt = 5'd8;
    #1;
    chk("nouse_vec", 32'(vec), 32'(V_NORM));
    step();

    // Hazard on rt.
    clr(); load_r8(); id_rt = 5'd8; id_uses_rt = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
    #1;
    chk("luse_rt_vec", 32'(vec & M_LUSE), 32'(V_LUSE));
    step();
    chk("luse_rt_cnt", 32'(stall_cnt), 32'd2);

    // Mult/div issue, three wait cycles, back to RUN.
    clr(); md_start = 1'b1;
    #1;
    chk("md_issue_vec", 32'(vec), 32'(V_NORM));
    step();
    clr(); branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("md_wait%0d_vec", i), 32'(vec), 32'(V_MDWAIT));
      chk($sformatf("md_wait%0d_busy", i), 32'(md_busy), 32'd1);
      step();
    end
    clr();
    #1;
    chk("md_done_vec", 32'(vec), 32'(V_NORM));
    chk("md_done_busy", 32'(md_busy), 32'd0);
    chk("md_done_cnt", 32'(stall_cnt), 32'd5);

    // Mult/div, then memory stall for 5 cycles starting with counter at 2.
    md_start = 1'b1;
    step();
    clr(); mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("ms%0d_vec", i), 32'(vec), 32'(V_FROZEN));
      chk($sformatf("ms%0d_busy", i), 32'(md_busy), 32'd1);
      step();
    end
    dmem_ready = 1'b1;
    #1;
    chk("ms_ready_vec", 32'(vec), 32'(V_MDWAIT));
    step();
    clr();
    #1;
    chk("ms_run_vec", 32'(vec), 32'(V_NORM));
    chk("ms_run_busy", 32'(md_busy), 32'd0);
    chk("ms_run_cnt", 32'(stall_cnt), 32'd11);

    // Memory stall in RUN holds state even with md_start present.
    mem_req = 1'b1; dmem_ready = 1'b0; md_start = 1'b1;
    #1;
    chk("ms_run_frozen", 32'(vec), 32'(V_FROZEN));
    step();
    clr();
    #1;
    chk("ms_hold_busy", 32'(md_busy), 32'd0);
    chk("ms_hold_cnt", 32'(stall_cnt), 32'd12);

    // Reset asserted in the second MD_WAIT cycle aborts at once.
    md_start = 1'b1;
    step();
    clr();
    step();
    reset = 1'b1;
    #1;
    chk("mdrst_vec", 32'(vec), 32'(V_FROZEN));
    chk("mdrst_busy", 32'(md_busy), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("mdrst_rel_vec", 32'(vec), 32'(V_NORM));
    chk("mdrst_rel_cnt", 32'(stall_cnt), 32'd0);
    step();
    chk("mdrst_run_busy", 32'(md_busy), 32'd0);

    // Counter saturation over 65540 frozen cycles.
    mem_req = 1'b1; dmem_ready = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_cnt", 32'(stall_cnt), 32'hFFFF);
    step();
    chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
    clr();
    #1;
    chk("sat_run_vec", 32'(vec), 32'(V_NORM));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 32-bit pipeline registers between the IF/ID, ID/EX, EX/MEM and MEM/WB stages, and for the PC register.
- Generates per-stage enable and flush strobes to:
  - hold stages on a load-use hazard;
  - bubble the front end during a multi-cycle mult/div;
  - freeze the whole pipe while data memory is not ready;
  - squash the fetched instruction on a taken branch.
- Also keeps a saturating stall-cycle counter for performance readout.

Parameters:
- RWIDTH, 5: register index width.
- MD_CYCLES, 32: mult/div latency in cycles, including the issue cycle; legal range 2..65535.
- CNT_W, 16: width of the stall_cnt performance counter.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- id_rs, in, RWIDTH: source register rs of the instruction in ID.
- id_rt, in, RWIDTH: source register rt of the instruction in ID.
- id_uses_rs, in, 1: the ID instruction reads rs.
- id_uses_rt, in, 1: the ID instruction reads rt.
- ex_rd, in, RWIDTH: destination register of the instruction in EX.
- ex_mem_read, in, 1: the EX instruction is a load.
- ex_reg_write, in, 1: the EX instruction writes the register file.
- md_start, in, 1: the ID instruction is a mult/div and issues this cycle.
- branch_taken, in, 1: branch resolved taken in ID.
- mem_req, in, 1: the EX/MEM stage holds a memory access.
- dmem_ready, in, 1: data memory has completed the access.
- pc_en, out, 1: PC load enable.
- ifid_en, out, 1: IF/ID register enable.
- ifid_flush, out, 1: clear IF/ID to a NOP.
- idex_en, out, 1: ID/EX register enable.
- idex_flush, out, 1: load a bubble into ID/EX.
- exmem_en, out, 1: EX/MEM register enable.
- exmem_flush, out, 1: load a bubble into EX/MEM.
- memwb_en, out, 1: MEM/WB register enable.
- md_busy, out, 1: mult/div in progress.
- stall_cnt, out, CNT_W: count of cycles with pc_en=0, saturating.

Behaviour:
- Reset:
  - While reset=1: state=RUN, md counter=0, stall_cnt=0, md_busy=0.
  - All enables and all flushes are 0 while reset is asserted.
  - After reset deasserts, the first edge operates as RUN.
- Outputs are combinational from the registered state plus current inputs; zero-cycle decision latency.
- memstall = mem_req & ~dmem_ready.
- luse (load-use hazard) = ex_mem_read & ex_reg_write & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
- Priority order (highest first): memstall, MD_WAIT, luse, branch_taken, normal.
- memstall, in any state:
  - All enables 0, all flushes 0; the whole pipe freezes.
  - FSM state is held.
  - The md counter keeps decrementing, because the divider runs independently.
- State RUN:
  - luse: pc_en=0, ifid_en=0, idex_flush=1; exmem_en=1, memwb_en=1. Exactly one bubble, with no state change.
  - Otherwise, if md_start: all enables 1 (the mult/div moves to EX). Next state is MD_WAIT with counter = MD_CYCLES-2, and md_busy=1 from the next cycle.
  - Otherwise, if branch_taken: all enables 1 and ifid_flush=1.
  - Otherwise: all enables 1, flushes 0.
  - md_start and branch_taken are ignored in a luse cycle; the ID instruction re-presents them after the stall.
- State MD_WAIT:
  - pc_en=0, ifid_en=0, idex_en=0; exmem_en=1 with exmem_flush=1 (bubbles drain downstream); memwb_en=1; md_busy=1.
  - The counter decrements each cycle.
  - When the counter is 0 and memstall=0: next state is RUN.
  - If the counter reaches 0 during memstall: it holds 0 and the FSM returns to RUN on the first cycle with memstall=0.
  - branch_taken, md_start and luse are ignored.
- stall_cnt: increments on every non-reset edge with pc_en=0, and saturates at all-ones.
- Register 0 never creates a hazard.
- A reset asserted mid-MD_WAIT aborts immediately to RUN with md_busy=0.

Decomposition:
- Shared package hazard_pkg:
  - state enum {RUN, MD_WAIT};
  - RWIDTH;
  - ZERO_REG constant.
- Sub-module load_use_detect: purely combinational luse compare. Reusable by the forwarding unit.

Test Plan:
- Load into r8 in EX (ex_mem_read=1, ex_reg_write=1, ex_rd=8); ID reads rs=8 -> exactly 1 cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1.
- Same setup but ex_rd=0, or id_uses_rs=0 -> no stall; all enables 1.
- md_start with MD_CYCLES=4:
  - required: 3 cycles of MD_WAIT with pc/ifid/idex_en=0, exmem_flush=1, md_busy=1;
  - then RUN;
  - stall_cnt=3.
- mem_req=1, dmem_ready=0 for 5 cycles during MD_WAIT with counter at 2 -> all enables 0 for 5 cycles; counter reaches 0; return to RUN on the first ready cycle.
- branch_taken with luse simultaneously -> stall only; next cycle branch_taken alone -> ifid_flush=1, pc_en=1.
- Assert reset at cycle 2 of MD_WAIT -> immediate all enables 0, md_busy=0; after release, RUN with stall_cnt=0. Also force 65540 stall cycles with CNT_W=16 -> stall_cnt holds 65535.
